// File: rtl/snd_pkg.sv
// Shared types for the stereo sample source: frame layout and playback FSM states.
package snd_pkg;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } snd_frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } snd_state_t;

endpackage

// File: rtl/snd_fifo.sv
// Single-clock frame FIFO on an inferred simple dual-port RAM with a registered read.
// Occupancy is kept in its own counter so that full and empty both come from one register.
// A flush empties the FIFO and wins over a push or pop issued in the same cycle.
module snd_fifo
  import snd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  snd_frame_t            wr_frame,
  output snd_frame_t            rd_frame,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  snd_frame_t            mem [DEPTH];
  snd_frame_t            rd_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Full is judged before any same-cycle pop, so a push at full is dropped.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_frame = rd_q;

  // RAM write port and registered read port; the read register holds until the next pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_frame;
    if (pop_ok)  rd_q <= mem[rd_ptr];
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/snd_stream_src.sv
// Producer side of the stereo sample interface: buffers frames from the register side and
// hands one frame to the delta-sigma stage per snd_next_sample once the FIFO has primed.
// Handshake: snd_next_sample is a one-cycle request; when it pops a frame, that frame appears
// on snd_l/snd_r in the following cycle and is held until the next pop (0 outside PLAY).
module snd_stream_src
  import snd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int PRIME_LVL  = 64,
  parameter int LOW_WATER  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [31:0]           wr_dat,
  output logic                  wr_full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  snd_next_sample,
  output logic signed [15:0]    snd_l,
  output logic signed [15:0]    snd_r,
  output logic                  snd_on,
  output logic                  underrun,
  input  logic                  clr_underrun,
  output logic                  low_irq,
  output snd_state_t            dbg_state
);

  localparam int LVL_W = DEPTH_LOG2 + 1;

  snd_state_t state;
  snd_state_t state_next;
  snd_frame_t rd_frame;
  logic       empty;
  logic       pop;
  logic       underrun_set;
  logic       out_valid;

  snd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (wr_req),
    .pop      (pop),
    .wr_frame (snd_frame_t'(wr_dat)),
    .rd_frame (rd_frame),
    .level    (level),
    .full     (wr_full),
    .empty    (empty)
  );

  assign dbg_state = state;
  assign snd_on    = (state == PLAY);
  assign snd_l     = out_valid ? rd_frame.l : '0;
  assign snd_r     = out_valid ? rd_frame.r : '0;

  // Playback state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state, pop and underrun decisions; disable outranks flush, flush outranks requests.
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    underrun_set = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else if (flush) begin
      state_next = (state == IDLE) ? IDLE : PRIME;
    end else begin
      case (state)
        IDLE:  state_next = PRIME;
        PRIME: if (level >= LVL_W'(PRIME_LVL)) state_next = PLAY;
        PLAY: begin
          if (snd_next_sample) begin
            if (empty) begin
              underrun_set = 1'b1;
              state_next   = PRIME;
            end else begin
              pop = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output gating, sticky underrun flag and low-water interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      low_irq   <= 1'b0;
    end else begin
      out_valid <= (state_next == PLAY) && (pop || out_valid);
      if (underrun_set)      underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
      low_irq <= (state == PLAY) && (level < LVL_W'(LOW_WATER));
    end
  end

endmodule
